// File: rtl/riscv_data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_data_mem_pkg
//  Description : Shared constants and types for the RISC-V data memory:
//                load/store size codes, fault-cause codes, FSM state enum
//                and a helper that tells legal size/direction combinations.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_data_mem_pkg;

  // Load/store size codes as driven by the core decoder
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  // Fault causes recorded in the sticky fault register
  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_RANGE    = 2'd2;
  localparam logic [1:0] FC_SIZE     = 2'd3;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Unsigned variants only exist as loads; a store with them is illegal.
  function automatic logic size_legal(input logic [2:0] size, input logic we);
    logic ok;
    case (size)
      LDST_B, LDST_H, LDST_W: ok = 1'b1;
      LDST_BU, LDST_HU:       ok = !we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_data_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_data_mem_if
//  Description : Core load/store port of the data memory.
//                mem_req  - access request
//                mem_we   - 1 store / 0 load
//                mem_size - LDST_* size code
//                mem_a    - byte address
//                mem_wd   - right-justified store data
//                mem_rd   - extended load data (combinational)
//                master = core side, slave = memory side.
//  Revision    : 1.0  initial release
// ============================================================================
interface riscv_data_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_size;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (output mem_req, mem_we, mem_size, mem_a, mem_wd, input mem_rd);
  modport slave  (input mem_req, mem_we, mem_size, mem_a, mem_wd, output mem_rd);
endinterface
`default_nettype wire

// File: rtl/riscv_data_mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_data_mem_lane_align
//  Description : Combinational byte-lane steering for the data memory.
//  Ports       : i_size    - LDST_* size code
//                i_a_lo    - byte offset within the word (MemA[1:0])
//                i_wd      - right-justified store data
//                i_rdata   - raw RAM word at the addressed location
//                o_be      - store byte-enable mask
//                o_wdata   - store data replicated onto every lane
//                o_ld_data - selected and sign/zero-extended load data
//  Revision    : 1.0  initial release
// ============================================================================
module riscv_data_mem_lane_align
  import riscv_data_mem_pkg::*;
(
  input  wire logic [2:0]  i_size,
  input  wire logic [1:0]  i_a_lo,
  input  wire logic [31:0] i_wd,
  input  wire logic [31:0] i_rdata,
  output logic      [3:0]  o_be,
  output logic      [31:0] o_wdata,
  output logic      [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_a_lo, 3'b000} +: 8];
  assign w_half = i_a_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Replicating store data onto all lanes lets the byte mask alone pick
  // the destination lane; no shifter is needed on the write path.
  always_comb begin
    o_be      = 4'b0000;
    o_wdata   = '0;
    o_ld_data = '0;
    case (i_size)
      LDST_B: begin
        o_be      = 4'b0001 << i_a_lo;
        o_wdata   = {4{i_wd[7:0]}};
        o_ld_data = {{24{w_byte[7]}}, w_byte};
      end
      LDST_BU: o_ld_data = {24'h0, w_byte};
      LDST_H: begin
        o_be      = i_a_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata   = {2{i_wd[15:0]}};
        o_ld_data = {{16{w_half[15]}}, w_half};
      end
      LDST_HU: o_ld_data = {16'h0, w_half};
      LDST_W: begin
        o_be      = 4'b1111;
        o_wdata   = i_wd;
        o_ld_data = i_rdata;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_data_mem
//  Description : Data-memory responder for the single-cycle RISC-V core.
//                Word-organised RAM with byte/half/word lanes, zero-latency
//                loads, zero-fill sweep after reset and a sticky fault
//                record (misaligned / out of range / illegal size).
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                if_mem          - core load/store port (slave modport)
//                o_ready         - high once the zero-fill sweep is done
//                o_fault         - sticky access-fault flag
//                o_fault_addr    - address of the first faulting access
//                o_fault_cause   - FC_* code of the first fault
//                o_tohost        - tohost register (DMEM_TOHOST_EN only)
//                o_tohost_valid  - pulse after a tohost store (DMEM_TOHOST_EN)
//  Config      : define DMEM_TOHOST_EN to add a tohost word register at
//                BASE_ADDR + 4*DEPTH.
//  Revision    : 1.0  initial release
// ============================================================================
module riscv_data_mem
  import riscv_data_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  riscv_data_mem_if.slave  if_mem,
  output logic             o_ready,
  output logic             o_fault,
  output logic [31:0]      o_fault_addr,
  output logic [1:0]       o_fault_cause
`ifdef DMEM_TOHOST_EN
  ,
  output logic [31:0]      o_tohost,
  output logic             o_tohost_valid
`endif
);

  localparam int AW = $clog2(DEPTH);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [31:0] r_ram [DEPTH];

  logic        r_fault;
  logic [31:0] r_fault_addr;
  logic [1:0]  r_fault_cause;

  logic [31:0] w_word;
  logic        w_below;
  logic        w_in_ram;
  logic        w_is_th;
  logic        w_fill;
  logic        w_active;
  logic [1:0]  w_cause;
  logic        w_store;
  logic        w_load;
  logic [31:0] w_raw;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;
  logic [31:0] w_th_rd;

  // ---------------- address decode ----------------
  assign w_below  = if_mem.mem_a < BASE_ADDR;
  assign w_word   = (if_mem.mem_a - BASE_ADDR) >> 2;
  assign w_in_ram = !w_below && (w_word < DEPTH);

`ifdef DMEM_TOHOST_EN
  // The tohost word sits immediately past the last RAM word.
  assign w_is_th = !w_below && (w_word == DEPTH);
`else
  assign w_is_th = 1'b0;
`endif

  // Priority: size, then range, then alignment.
  always_comb begin
    w_cause = FC_NONE;
    if (!size_legal(if_mem.mem_size, if_mem.mem_we))
      w_cause = FC_SIZE;
    else if (!(w_in_ram || w_is_th))
      w_cause = FC_RANGE;
    else if (w_is_th && (if_mem.mem_size != LDST_W))
      w_cause = FC_MISALIGN;
    else if (((if_mem.mem_size == LDST_H) || (if_mem.mem_size == LDST_HU)) && if_mem.mem_a[0])
      w_cause = FC_MISALIGN;
    else if ((if_mem.mem_size == LDST_W) && (if_mem.mem_a[1:0] != 2'b00))
      w_cause = FC_MISALIGN;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_cnt == AW'(DEPTH - 1)) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    o_ready = (r_state == ST_RUN);
    w_fill  = (r_state == ST_INIT);
  end

  // Sweep counter wraps back to 0 on the last fill write; it is idle in RUN.
  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (w_fill) r_cnt <= r_cnt + 1'b1;
  end

  // ---------------- datapath ----------------
  assign w_active = if_mem.mem_req && o_ready;
  assign w_store  = w_active && (w_cause == FC_NONE) && if_mem.mem_we;
  assign w_load   = w_active && (w_cause == FC_NONE) && !if_mem.mem_we;
  assign w_raw    = r_ram[w_word[AW-1:0]];

  riscv_data_mem_lane_align u_lane_align (
    .i_size    (if_mem.mem_size),
    .i_a_lo    (if_mem.mem_a[1:0]),
    .i_wd      (if_mem.mem_wd),
    .i_rdata   (w_raw),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_ld_data (w_ld_data)
  );

  // RAM has no reset of its own; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fill) begin
        r_ram[r_cnt] <= '0;
      end else if (w_store && !w_is_th) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_ram[w_word[AW-1:0]][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign if_mem.mem_rd = !w_load ? 32'h0 : (w_is_th ? w_th_rd : w_ld_data);

  // ---------------- sticky fault record ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault       <= 1'b0;
      r_fault_addr  <= '0;
      r_fault_cause <= FC_NONE;
    end else if (w_active && (w_cause != FC_NONE) && !r_fault) begin
      r_fault       <= 1'b1;
      r_fault_addr  <= if_mem.mem_a;
      r_fault_cause <= w_cause;
    end
  end

  assign o_fault       = r_fault;
  assign o_fault_addr  = r_fault_addr;
  assign o_fault_cause = r_fault_cause;

  // ---------------- tohost ----------------
`ifdef DMEM_TOHOST_EN
  logic [31:0] r_tohost;
  logic        r_tohost_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tohost       <= '0;
      r_tohost_valid <= 1'b0;
    end else begin
      r_tohost_valid <= w_store && w_is_th;
      if (w_store && w_is_th) r_tohost <= if_mem.mem_wd;
    end
  end

  assign w_th_rd        = r_tohost;
  assign o_tohost       = r_tohost;
  assign o_tohost_valid = r_tohost_valid;
`else
  assign w_th_rd = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_data_mem
//  Description : Self-checking bench for riscv_data_mem (DEPTH=16). A
//                byte-addressed reference model tracks RAM contents, the
//                sweep countdown and the first-fault record.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_riscv_data_mem;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam longint      MEMB  = longint'(4 * DEPTH);
`ifdef DMEM_TOHOST_EN
  localparam bit TH_EN = 1'b1;
`else
  localparam bit TH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_data_mem_if bus ();
  logic        ready;
  logic        fault;
  logic [31:0] faddr;
  logic [1:0]  fcause;
`ifdef DMEM_TOHOST_EN
  logic [31:0] tohost;
  logic        tohost_valid;
`endif

  riscv_data_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_mem        (bus),
    .o_ready       (ready),
    .o_fault       (fault),
    .o_fault_addr  (faddr),
`ifdef DMEM_TOHOST_EN
    .o_fault_cause (fcause),
    .o_tohost      (tohost),
    .o_tohost_valid(tohost_valid)
`else
    .o_fault_cause (fcause)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [7:0]  m_mem [4*DEPTH];
  int          m_left = DEPTH;
  logic        m_fault;
  logic [31:0] m_faddr;
  logic [1:0]  m_fcause;
  logic [31:0] m_tohost;
  logic [31:0] last_rd;

  logic [2:0]  sz_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd3, 3'd6};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int nbytes(input logic [2:0] size);
    return (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [1:0] m_cause(input logic we, input logic [2:0] size, input logic [31:0] a);
    longint off;
    bit     legal, in_ram, th;
    int     n;
    legal = we ? (size <= 3'd2) : (size <= 3'd2 || size == 3'd4 || size == 3'd5);
    if (!legal) return 2'd3;
    off    = longint'(a) - longint'(BASE);
    n      = nbytes(size);
    in_ram = (off >= 0) && (off < MEMB);
    th     = TH_EN && (off >= MEMB) && (off < MEMB + 4);
    if (!in_ram && !th) return 2'd2;
    if (th && n != 4) return 2'd1;
    if ((off % longint'(n)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] size, input logic [31:0] a);
    int          i;
    logic [15:0] h;
    i = int'(a - BASE);
    if (TH_EN && longint'(i) == MEMB) return m_tohost;
    h = (size[1:0] == 2'd0) ? 16'h0 : {m_mem[i+1], m_mem[i]};
    case (size)
      3'd0:    return {{24{m_mem[i][7]}}, m_mem[i]};
      3'd4:    return {24'h0, m_mem[i]};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'h0, h};
      default: return {m_mem[i+3], m_mem[i+2], m_mem[i+1], m_mem[i]};
    endcase
  endfunction

  task automatic m_store(input logic [2:0] size, input logic [31:0] a, input logic [31:0] wd);
    int i;
    i = int'(a - BASE);
    if (TH_EN && longint'(i) == MEMB) m_tohost = wd;
    else for (int k = 0; k < nbytes(size); k++) m_mem[i+k] = wd[8*k +: 8];
  endtask

  task automatic m_clear();
    for (int i = 0; i < 4*DEPTH; i++) m_mem[i] = 8'h00;
    m_fault = 1'b0; m_faddr = 32'h0; m_fcause = 2'd0; m_tohost = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (m_left > 0) m_left--;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_req = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_left = DEPTH;
    m_clear();
  endtask

  task automatic wait_ready(input int exp_cycles);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_latency", 32'(n), 32'(exp_cycles));
  endtask

  // One request cycle: drive, sample the combinational read at mid-cycle,
  // update the model, cross the edge, then compare the fault record.
  task automatic access(input logic req, input logic we, input logic [2:0] size,
                        input logic [31:0] a, input logic [31:0] wd);
    logic [1:0]  c;
    logic        active;
    logic [31:0] exp_rd;
`ifdef DMEM_TOHOST_EN
    logic        th;
    th = ((a - BASE) == 32'(MEMB));
`endif
    bus.mem_req = req; bus.mem_we = we; bus.mem_size = size; bus.mem_a = a; bus.mem_wd = wd;
    #4;
    c      = m_cause(we, size, a);
    active = req && (m_left == 0);
    exp_rd = (active && c == 2'd0 && !we) ? m_load(size, a) : 32'h0;
    last_rd = bus.mem_rd;
    if (!(active && we && c == 2'd0)) chk("mem_rd", bus.mem_rd, exp_rd);
    chk("ready", 32'(ready), 32'(m_left == 0));
    if (active) begin
      if (c != 2'd0) begin
        if (!m_fault) begin
          m_fault = 1'b1; m_faddr = a; m_fcause = c;
        end
      end else if (we) begin
        m_store(size, a, wd);
      end
    end
    tick();
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_addr", faddr, m_faddr);
    chk("fault_cause", 32'(fcause), 32'(m_fcause));
`ifdef DMEM_TOHOST_EN
    chk("tohost_valid", 32'(tohost_valid), 32'(active && we && c == 2'd0 && th));
    chk("tohost", tohost, m_tohost);
`endif
    bus.mem_req = 1'b0;
  endtask

  initial begin
    logic [2:0]  sz;
    logic [31:0] a;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_size = 3'd0;
    bus.mem_a = 32'h0; bus.mem_wd = 32'h0;
    m_clear();

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_faddr", faddr, 32'h0);
    chk("rst_fcause", 32'(fcause), 32'h0);
    chk("rst_rd", bus.mem_rd, 32'h0);
    rst    = 1'b0;
    m_left = DEPTH;
    wait_ready(DEPTH);

    // lane tests
    access(1, 0, 3'd2, 32'h8, 0);             chk("lw8_zero", last_rd, 32'h0);
    access(1, 1, 3'd2, 32'h8, 32'h8899AABB);
    access(1, 0, 3'd0, 32'h9, 0);             chk("lb9", last_rd, 32'hFFFFFFAA);
    access(1, 0, 3'd4, 32'h9, 0);             chk("lbu9", last_rd, 32'h000000AA);
    access(1, 0, 3'd1, 32'hA, 0);             chk("lhA", last_rd, 32'hFFFF8899);
    access(1, 0, 3'd2, 32'h8, 0);             chk("lw8", last_rd, 32'h8899AABB);
    access(1, 1, 3'd0, 32'hB, 32'h00000012);
    access(1, 0, 3'd2, 32'h8, 0);             chk("lw8_sb", last_rd, 32'h1299AABB);
    access(1, 1, 3'd1, 32'h8, 32'h00003456);
    access(1, 0, 3'd2, 32'h8, 0);             chk("lw8_sh", last_rd, 32'h12993456);

    // faults: first one sticks, out-of-range store dropped
    access(1, 0, 3'd2, 32'h6, 0);
    access(1, 1, 3'd2, 32'h100, 32'hDEADBEEF);
    chk("fault_set", 32'(fault), 32'h1);
    chk("fault_addr6", faddr, 32'h6);
    chk("fault_cause1", 32'(fcause), 32'h1);
    access(1, 0, 3'd2, 32'h0, 0);             chk("oob_dropped", last_rd, 32'h0);

    // reset pulsed mid-sweep; requests during INIT are ignored
    do_reset();
    for (int i = 0; i < 7; i++) access(1, 1'(i & 1), 3'(i % 4 + 2), 32'(i * 3 + 1), 32'hFFFFFFFF);
    do_reset();
    wait_ready(DEPTH);
    chk("fault_cleared", 32'(fault), 32'h0);
    access(1, 0, 3'd2, 32'h8, 0);             chk("rezeroed", last_rd, 32'h0);

    // idle with bad inputs, then illegal size
    access(0, 1, 3'd3, 32'h7, 32'h1);
    access(1, 0, 3'd3, 32'h10, 0);
    chk("size_cause", 32'(fcause), 32'h3);
    chk("size_addr", faddr, 32'h10);

`ifdef DMEM_TOHOST_EN
    access(1, 1, 3'd2, 32'(MEMB), 32'hCAFE0001);
    access(1, 0, 3'd2, 32'(MEMB), 0);         chk("tohost_ld", last_rd, 32'hCAFE0001);
`endif

    // randomized traffic, re-arming the fault record periodically
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) begin
        do_reset();
        wait_ready(DEPTH);
      end
      sz = sz_tab[$urandom_range(0, 9)];
      a  = 32'($urandom_range(0, 4*DEPTH + 11));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
      access(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), sz, a, 32'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/riscv_data_mem.md
# riscv_data_mem

Data-memory responder for the single-cycle RISC-V core: serves the core's load/store port (MemReq, MemWE, MemSize, MemA, MemWD → MemRD). It provides a word-organised RAM with byte/half/word lanes, sign or zero extension on loads, and a reset-time zero-fill sweep. A sticky fault record catches misaligned, out-of-range and bad-size accesses. It sits beside the instruction memory at top level; Ready gates the core's PC enable.

## Interface
- DEPTH, 1024: RAM size in 32-bit words; power of two, ≥ 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; word-aligned.
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- MemReq  in  1  access request from core decoder.
- MemWE  in  1  1 = store, 0 = load; valid only with MemReq.
- MemSize  in  3  0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU; others illegal.
- MemA  in  32  byte address (core ALU result).
- MemWD  in  32  store data, right-justified.
- MemRD  out  32  load data, extended per MemSize; combinational.
- Ready  out  1  1 once zero-fill is complete.
- Fault  out  1  sticky access-fault flag.
- FaultAddr  out  32  MemA of the first faulting access.
- FaultCause  out  2  0 none, 1 misaligned, 2 out of range, 3 illegal size.

## Operation
- FSM states: INIT, RUN.
- INIT: a word counter zeroes ram[cnt] on each cycle, from 0 to DEPTH-1. Transition to RUN on the cycle that writes word DEPTH-1. In INIT: Ready=0, MemRD=0, all requests ignored, no fault recorded.
- RUN: Ready=1. The access is checked in this order: illegal size; then out of range (MemA < BASE_ADDR, or word index (MemA-BASE_ADDR)>>2 ≥ DEPTH); then misaligned (half with MemA[0]=1, word with MemA[1:0]≠0). First matching cause wins.
- Faulting access: no RAM write; MemRD=0. If Fault=0, set Fault=1 and capture FaultAddr and FaultCause. Later faults never overwrite the record.
- Load (MemReq=1, MemWE=0, legal): select lane by MemA[1:0]. Size 0/1 sign-extend; size 4/5 zero-extend; size 2 passes the word.
- Store (legal): byte-enable mask from size and MemA[1:0]. MemWD byte 0 (or halfword 0) is replicated to the addressed lane. Unmasked bytes are preserved.
- MemSize 4/5 with MemWE=1 is an illegal size.
- MemReq=0: MemRD=0, no write, no fault check.

## Timing
- Reset values: Ready=0, Fault=0, FaultAddr=0, FaultCause=0, MemRD=0. State=INIT, cnt=0.
- RESET asserted in any state, including mid-sweep, restarts INIT at cnt=0 on the next edge. RAM contents are then re-zeroed over DEPTH cycles.
- Ready rises DEPTH cycles after the first edge with RESET low.
- Load latency: 0 cycles. MemRD is a combinational function of the RAM and inputs in the same cycle.
- Store: committed on the rising edge that ends the request cycle. A load to the same address in the next cycle returns the new data.
- Fault/FaultAddr/FaultCause update on the edge ending the faulting cycle.

## Configuration
- DMEM_TOHOST_EN defined: adds a tohost register at byte address BASE_ADDR + 4·DEPTH.
  - Word stores to it are legal and latch MemWD; loads return the latched value.
  - Reset value 0.
  - Adds outputs ToHost[31:0] and ToHostValid. ToHostValid is a one-cycle pulse after each store.
  - Non-word accesses to that address fault as misaligned.
- DMEM_TOHOST_EN undefined: that address is out of range, like any other address beyond the RAM. ToHost and ToHostValid are absent.

## Structure
- Shared package riscv_pkg:
  - LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5.
  - Fault-cause constants FC_NONE, FC_MISALIGN, FC_RANGE, FC_SIZE.
  - FSM state enum.
- Sub-module dmem_lane_align (combinational): MemSize + MemA[1:0] + MemWD + raw word → byte mask, shifted store data, extended load data.

## Test plan
- Reset with DEPTH=16 → Ready=0 for 16 cycles, then 1. Load from 0x8 returns 0.
- SW 0x8 ← 0x8899AABB, then LB 0x9 → 0xFFFFFFAA, LBU 0x9 → 0x000000AA, LH 0xA → 0xFFFF8899, LW → 0x8899AABB.
- SB 0xB ← 0x12 over the previous word → LW 0x8 = 0x1299AABB. SH 0x8 ← 0x3456 → LW = 0x12993456.
- LW 0x6 (misaligned), then SW 0x100 (out of range) → Fault=1, FaultAddr=0x6, FaultCause=1. The store is not performed.
- MemSize=3 with MemReq=1 → FaultCause=3 on a clean part. MemReq=0 with bad inputs → no fault.
- RESET pulsed mid-sweep at cnt=7 → Ready stays low for a full 16 further cycles; Fault is cleared.
